// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: detects load-use hazards that forwarding cannot bypass.
// On such a hazard it holds PC and IF/ID and loads a bubble into ID/EXE. A
// small FSM sequences the two-bubble case of a branch in ID that depends on
// a load still in EXE.
//
// Optional feature macro: HAZARD_PERF_EN adds the perf_* counter ports.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   freeze                    global pipeline hold, overrides everything
//   IFID_rs/rt/use_rt/DMWr    operands and store type of the ID instruction
//   IFID_branch               ID instruction resolves a branch/jr in ID
//   IDEXE_rd/RFWr/DMRd        EXE-stage producer
//   EXEMEM_rd/RFWr/DMRd       MEM-stage producer
//   PC_stall, IFID_stall      hold PC and IF/ID (combinational, Mealy in S_RUN)
//   IDEXE_flush               load a bubble into ID/EXE
//   hz_state                  FSM state, for debug
//   perf_*                    (HAZARD_PERF_EN) stall-cycle and event counters
module hazard_stall_unit #(
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          freeze,
  input  logic [RW-1:0] IFID_rs,
  input  logic [RW-1:0] IFID_rt,
  input  logic          IFID_use_rt,
  input  logic [1:0]    IFID_DMWr,
  input  logic          IFID_branch,
  input  logic [RW-1:0] IDEXE_rd,
  input  logic          IDEXE_RFWr,
  input  logic [3:0]    IDEXE_DMRd,
  input  logic [RW-1:0] EXEMEM_rd,
  input  logic          EXEMEM_RFWr,
  input  logic [3:0]    EXEMEM_DMRd,
`ifdef HAZARD_PERF_EN
  output logic [CW-1:0] perf_stall_cycles,
  output logic [CW-1:0] perf_lu_events,
  output logic [CW-1:0] perf_br_events,
`endif
  output logic          PC_stall,
  output logic          IFID_stall,
  output logic          IDEXE_flush,
  output logic [1:0]    hz_state
);

  localparam int unsigned DMWR_W = 2;
  localparam int unsigned DMRD_W = 4;
  localparam logic [DMWR_W-1:0] DMWR_NOP = DMWR_W'(0);
  localparam logic [DMRD_W-1:0] DMRD_NOP = DMRD_W'(0);
  localparam logic [RW-1:0]     REG_ZERO = RW'(0);
  localparam logic [RW-1:0]     REG_RA   = RW'(31);

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_BR2 = 2'd1,
    S_LU  = 2'd2
  } hz_state_e;

  // Parameter sanity checks at elaboration.
  if (CW < 1) begin : g_cw_chk
    $error("hazard_stall_unit: CW must be at least 1");
  end
  if (RW < 5) begin : g_rw_chk
    $error("hazard_stall_unit: RW must be at least 5");
  end

  hz_state_e state, next_state;
  logic      stall;

  logic ex_load, mem_load, id_store;
  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic h1, h2;

  // Producer qualification: live (writes a real register) and a load.
  assign ex_load  = IDEXE_RFWr && (IDEXE_rd != REG_ZERO) && (IDEXE_rd != REG_RA)
                    && (IDEXE_DMRd != DMRD_NOP);
  assign mem_load = EXEMEM_RFWr && (EXEMEM_rd != REG_ZERO) && (EXEMEM_rd != REG_RA)
                    && (EXEMEM_DMRd != DMRD_NOP);
  assign id_store = (IFID_DMWr != DMWR_NOP);

  assign ex_rs  = (IFID_rs == IDEXE_rd);
  assign ex_rt  = IFID_use_rt && (IFID_rt == IDEXE_rd);
  assign mem_rs = (IFID_rs == EXEMEM_rd);
  assign mem_rt = IFID_use_rt && (IFID_rt == EXEMEM_rd);

  // Store data on rt reaches MEM through MEM-to-MEM forwarding, so a store's
  // rt match is not a hazard unless the store side is a branch operand.
  assign h2 = IFID_branch && ex_load && (ex_rs || ex_rt);
  assign h1 = (!IFID_branch && ex_load && (ex_rs || (ex_rt && !id_store)))
           || (IFID_branch && mem_load && (mem_rs || mem_rt));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_RUN;
    else       state <= next_state;
  end

  // Next state and raw stall; freeze holds the state in place.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    case (state)
      S_RUN: begin
        stall = h1 || h2;
        if (h2)      next_state = S_BR2;
        else if (h1) next_state = S_LU;
      end
      S_BR2: begin
        stall      = 1'b1;
        next_state = S_LU;
      end
      S_LU:    next_state = S_RUN;
      default: next_state = S_RUN;
    endcase
    if (freeze) next_state = state;
  end

  // Gated by rstn so a reset mid-stall drops the outputs without a clock.
  assign PC_stall    = stall && !freeze && rstn;
  assign IFID_stall  = PC_stall;
  assign IDEXE_flush = PC_stall;
  assign hz_state    = state;

`ifdef HAZARD_PERF_EN
  logic lu_entry, br_entry;
  assign br_entry = (state == S_RUN) && !freeze && h2;
  assign lu_entry = (state == S_RUN) && !freeze && h1 && !h2;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall_cycles <= '0;
      perf_lu_events    <= '0;
      perf_br_events    <= '0;
    end else begin
      if (PC_stall) perf_stall_cycles <= perf_stall_cycles + CW'(1);
      if (lu_entry) perf_lu_events    <= perf_lu_events + CW'(1);
      if (br_entry) perf_br_events    <= perf_br_events + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rstn;
  logic       freeze;
  logic [4:0] IFID_rs, IFID_rt;
  logic       IFID_use_rt;
  logic [1:0] IFID_DMWr;
  logic       IFID_branch;
  logic [4:0] IDEXE_rd;
  logic       IDEXE_RFWr;
  logic [3:0] IDEXE_DMRd;
  logic [4:0] EXEMEM_rd;
  logic       EXEMEM_RFWr;
  logic [3:0] EXEMEM_DMRd;
  logic       PC_stall, IFID_stall, IDEXE_flush;
  logic [1:0] hz_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_lu_events, perf_br_events;
`endif

  hazard_stall_unit #(.RW(5), .CW(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .freeze      (freeze),
    .IFID_rs     (IFID_rs),
    .IFID_rt     (IFID_rt),
    .IFID_use_rt (IFID_use_rt),
    .IFID_DMWr   (IFID_DMWr),
    .IFID_branch (IFID_branch),
    .IDEXE_rd    (IDEXE_rd),
    .IDEXE_RFWr  (IDEXE_RFWr),
    .IDEXE_DMRd  (IDEXE_DMRd),
    .EXEMEM_rd   (EXEMEM_rd),
    .EXEMEM_RFWr (EXEMEM_RFWr),
    .EXEMEM_DMRd (EXEMEM_DMRd),
`ifdef HAZARD_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_lu_events    (perf_lu_events),
    .perf_br_events    (perf_br_events),
`endif
    .PC_stall    (PC_stall),
    .IFID_stall  (IFID_stall),
    .IDEXE_flush (IDEXE_flush),
    .hz_state    (hz_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic       stl;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_stall_cnt = 0;
  int   exp_lu_cnt = 0;
  int   exp_br_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pop one expected entry and compare it to the live outputs.
  task automatic compare(input string tag);
    exp_t e;
    check({tag, ":sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, ":hz_state"}, 32'(hz_state), 32'(e.st));
      check({tag, ":PC_stall"}, 32'(PC_stall), 32'(e.stl));
      check({tag, ":IFID_stall"}, 32'(IFID_stall), 32'(e.stl));
      check({tag, ":IDEXE_flush"}, 32'(IDEXE_flush), 32'(e.stl));
    end
  endtask

  // One clock cycle with the current inputs; called at posedge+1.
  task automatic cyc(input string tag, input logic [1:0] st, input logic stl);
    exp_t e;
    e.st = st;
    e.stl = stl;
    sb_q.push_back(e);
    if (stl) exp_stall_cnt++;
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    freeze = 1'b0;
    IFID_rs = '0; IFID_rt = '0; IFID_use_rt = 1'b0; IFID_DMWr = '0; IFID_branch = 1'b0;
    IDEXE_rd = '0; IDEXE_RFWr = 1'b0; IDEXE_DMRd = '0;
    EXEMEM_rd = '0; EXEMEM_RFWr = 1'b0; EXEMEM_DMRd = '0;
  endtask

  task automatic ex_load(input logic [4:0] rd);
    IDEXE_rd = rd; IDEXE_RFWr = 1'b1; IDEXE_DMRd = 4'd3;
  endtask

  task automatic mem_load(input logic [4:0] rd);
    EXEMEM_rd = rd; EXEMEM_RFWr = 1'b1; EXEMEM_DMRd = 4'd1;
  endtask

  task automatic check_perf(input string tag, input int s, input int l, input int b);
`ifdef HAZARD_PERF_EN
    check({tag, ":perf_stall"}, perf_stall_cycles, 32'(s));
    check({tag, ":perf_lu"}, perf_lu_events, 32'(l));
    check({tag, ":perf_br"}, perf_br_events, 32'(b));
`else
    if (s + l + b < 0) $display("unreachable %s", tag);
`endif
  endtask

  function automatic logic live_load(logic w, logic [4:0] rd, logic [3:0] rdm);
    return w && (rd != 5'd0) && (rd != 5'd31) && (rdm != 4'd0);
  endfunction

  initial begin
    logic [1:0] mst;
    logic [4:0] pick [4];
    exp_t e;
    pick[0] = 5'd0; pick[1] = 5'd8; pick[2] = 5'd9; pick[3] = 5'd31;

    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e.st = 2'd0; e.stl = 1'b0; sb_q.push_back(e);
    compare("reset");
    check_perf("reset", 0, 0, 0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // lw $8 in EXE, add rs=8 in ID: one bubble.
    ex_load(5'd8); IFID_rs = 5'd8;
    cyc("lu_add", 2'd0, 1'b1); exp_lu_cnt++;
    idle(); mem_load(5'd8); IFID_rs = 5'd8;
    cyc("lu_add_done", 2'd2, 1'b0);
    cyc("lu_add_run", 2'd0, 1'b0);
    idle();

    // lw $8 in EXE, beq rt=8 in ID: two bubbles.
    ex_load(5'd8); IFID_rt = 5'd8; IFID_use_rt = 1'b1; IFID_branch = 1'b1;
    cyc("br2_a", 2'd0, 1'b1); exp_br_cnt++;
    IDEXE_RFWr = 1'b0; mem_load(5'd8);
    cyc("br2_b", 2'd1, 1'b1);
    EXEMEM_RFWr = 1'b0;
    cyc("br2_lu", 2'd2, 1'b0);
    cyc("br2_run", 2'd0, 1'b0);
    idle();

    // lw $9 in MEM, beq rs=9 in ID: one bubble; rd 0 and 31 never stall.
    mem_load(5'd9); IFID_rs = 5'd9; IFID_branch = 1'b1;
    cyc("br1", 2'd0, 1'b1); exp_lu_cnt++;
    EXEMEM_RFWr = 1'b0;
    cyc("br1_lu", 2'd2, 1'b0);
    mem_load(5'd0); IFID_rs = 5'd0;
    cyc("br1_r0", 2'd0, 1'b0);
    mem_load(5'd31); IFID_rs = 5'd31;
    cyc("br1_r31", 2'd0, 1'b0);
    idle();

    // Store exemption on rt, but not on rs.
    ex_load(5'd8); IFID_rt = 5'd8; IFID_rs = 5'd4; IFID_use_rt = 1'b1; IFID_DMWr = 2'd1;
    cyc("sw_rt", 2'd0, 1'b0);
    IFID_rs = 5'd8;
    cyc("sw_rs", 2'd0, 1'b1); exp_lu_cnt++;
    idle();
    cyc("sw_lu", 2'd2, 1'b0);
    cyc("sw_run", 2'd0, 1'b0);

    // Freeze in S_RUN masks the stall and holds the state.
    ex_load(5'd8); IFID_rs = 5'd8; freeze = 1'b1;
    cyc("frz_run", 2'd0, 1'b0);
    idle();
    cyc("frz_run_rel", 2'd0, 1'b0);

    // H2 then freeze for 3 cycles inside S_BR2.
    ex_load(5'd8); IFID_rs = 5'd8; IFID_branch = 1'b1;
    cyc("frz_h2", 2'd0, 1'b1); exp_br_cnt++;
    idle(); freeze = 1'b1;
    for (int i = 0; i < 3; i++) cyc("frz_br2", 2'd1, 1'b0);
    freeze = 1'b0;
    cyc("frz_rel", 2'd1, 1'b1);
    cyc("frz_lu", 2'd2, 1'b0);
    cyc("frz_run", 2'd0, 1'b0);
    check_perf("pre_rst", exp_stall_cnt, exp_lu_cnt, exp_br_cnt);

    // Asynchronous reset in S_BR2 with the hazard inputs still present.
    ex_load(5'd8); IFID_rs = 5'd8; IFID_branch = 1'b1;
    cyc("rst_h2", 2'd0, 1'b1);
    rstn = 1'b0;
    #1;
    e.st = 2'd0; e.stl = 1'b0; sb_q.push_back(e);
    compare("rst_async");
    check_perf("rst_async", 0, 0, 0);
    idle();
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    exp_stall_cnt = 0; exp_lu_cnt = 0; exp_br_cnt = 0;
    cyc("rst_run", 2'd0, 1'b0);

    // Random traffic against an independent cycle model.
    mst = 2'd0;
    for (int n = 0; n < 120; n++) begin
      logic exl, mml, rs_e, rt_e, rs_m, rt_m, hh1, hh2, stl, st;
      logic [1:0] nst;
      freeze      = ($urandom_range(0, 4) == 0);
      IFID_rs     = pick[$urandom_range(0, 3)];
      IFID_rt     = pick[$urandom_range(0, 3)];
      IFID_use_rt = 1'($urandom_range(0, 1));
      IFID_DMWr   = 2'($urandom_range(0, 3));
      IFID_branch = 1'($urandom_range(0, 1));
      IDEXE_rd    = pick[$urandom_range(0, 3)];
      IDEXE_RFWr  = 1'($urandom_range(0, 1));
      IDEXE_DMRd  = ($urandom_range(0, 1) == 1) ? 4'd2 : 4'd0;
      EXEMEM_rd   = pick[$urandom_range(0, 3)];
      EXEMEM_RFWr = 1'($urandom_range(0, 1));
      EXEMEM_DMRd = ($urandom_range(0, 1) == 1) ? 4'd5 : 4'd0;
      exl  = live_load(IDEXE_RFWr, IDEXE_rd, IDEXE_DMRd);
      mml  = live_load(EXEMEM_RFWr, EXEMEM_rd, EXEMEM_DMRd);
      rs_e = (IFID_rs == IDEXE_rd);
      rt_e = IFID_use_rt && (IFID_rt == IDEXE_rd);
      rs_m = (IFID_rs == EXEMEM_rd);
      rt_m = IFID_use_rt && (IFID_rt == EXEMEM_rd);
      if (IFID_branch) begin
        hh2 = exl && (rs_e || rt_e);
        hh1 = mml && (rs_m || rt_m);
      end else begin
        hh2 = 1'b0;
        hh1 = exl && (rs_e || (rt_e && (IFID_DMWr == 2'd0)));
      end
      st  = (mst == 2'd1) || ((mst == 2'd0) && (hh1 || hh2));
      stl = st && !freeze;
      if (freeze)             nst = mst;
      else if (mst == 2'd1)   nst = 2'd2;
      else if (mst == 2'd2)   nst = 2'd0;
      else if (hh2)           nst = 2'd1;
      else if (hh1)           nst = 2'd2;
      else                    nst = 2'd0;
      if (!freeze && mst == 2'd0 && hh2) exp_br_cnt++;
      if (!freeze && mst == 2'd0 && hh1 && !hh2) exp_lu_cnt++;
      cyc("rnd", mst, stl);
      mst = nst;
    end
    check_perf("rnd_end", exp_stall_cnt, exp_lu_cnt, exp_br_cnt);

    idle();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall and bubble generator for the 5-stage pipeline, the counterpart of the forwarding logic. Forwarding resolves every RAW dependence that can be bypassed; this block detects the cases that cannot be bypassed and freezes PC and IF/ID while injecting a bubble into ID/EXE. It sits beside the ID stage and holds a small FSM so that multi-cycle branch stalls behind a load are sequenced explicitly. The FSM does not rely on re-detection.

## Interface
Parameters:
- `RW`, 5, register index width.
- `CW`, 32, width of optional performance counters.

Ports:
- `clk` input 1: rising-edge clock.
- `rstn` input 1: asynchronous, active-low reset.
- `freeze` input 1: global pipeline hold, e.g. DM busy. Overrides everything.
- `IFID_rs`, `IFID_rt` input RW: source registers of the instruction in ID.
- `IFID_use_rt` input 1: the ID instruction reads rt as an ALU/branch operand.
- `IFID_DMWr` input 2: ID store type; `DMWr_NOP` means not a store.
- `IFID_branch` input 1: the ID instruction resolves a branch/jr in ID.
- `IDEXE_rd` input RW; `IDEXE_RFWr` input 1; `IDEXE_DMRd` input 4: EXE-stage producer.
- `EXEMEM_rd` input RW; `EXEMEM_RFWr` input 1; `EXEMEM_DMRd` input 4: MEM-stage producer.
- `PC_stall` output 1: hold PC.
- `IFID_stall` output 1: hold IF/ID.
- `IDEXE_flush` output 1: load a bubble into ID/EXE.
- `hz_state` output 2: FSM state, for debug.

## Operation
- A producer is live when `RFWr`=1, `rd`≠0 and `rd`≠31.
- A producer is a load when `DMRd`≠`DMRd_NOP`. Encodings come from the control-encode defines.
- `m_rs` is `IFID_rs`==rd. `m_rt` is `IFID_use_rt` && `IFID_rt`==rd.
- Store exemption: when `IFID_DMWr`≠`DMWr_NOP`, `m_rt` is ignored for non-branch hazards. MEM2MEM data forwarding covers it.
- Hazard classes, evaluated in `S_RUN` only:
  - H2 (2 bubbles): `IFID_branch`, IDEXE live load, `m_rs`|`m_rt` against IDEXE.
  - H1 (1 bubble), non-branch case: IDEXE live load, `m_rs`|`m_rt` against IDEXE.
  - H1 (1 bubble), branch case: `IFID_branch`, EXEMEM live load, `m_rs`|`m_rt` against EXEMEM.
  - Priority is H2 over H1.
- FSM states: `S_RUN`=0, `S_BR2`=1, `S_LU`=2.
  - In `S_RUN`: H2 goes to `S_BR2`, H1 goes to `S_LU`, otherwise stay.
  - `S_BR2` always goes to `S_LU`.
  - `S_LU` always goes to `S_RUN`.
- Stall outputs: `stall` = (`S_RUN` && (H1|H2)) || `S_BR2`. This is Mealy in `S_RUN`.
- `S_LU` is a registered "bubble done" cycle. Outputs are 0 there and detection is suppressed, so a single dependence never double-stalls.
- `PC_stall` = `IFID_stall` = `IDEXE_flush` = `stall` && !`freeze`.
- While `freeze`=1:
  - The state holds.
  - All three outputs are 0, because the pipeline is already held.
  - Detection is re-evaluated after release.
- Reset mid-stall: the FSM returns to `S_RUN` immediately and the outputs drop asynchronously.

## Timing
- Reset values: `hz_state`=0. `PC_stall`, `IFID_stall` and `IDEXE_flush` are 0. Counters are 0.
- Detection to stall has zero latency, combinational in the same cycle.
- H1 produces exactly 1 stall cycle. H2 produces exactly 2 consecutive stall cycles.
- `freeze` asserted during `S_BR2` stretches the sequence. Stall cycles resume when it drops.
- Back-to-back dependent pairs are separated by the mandatory `S_LU` cycle. Minimum spacing between stall sequences is 1 non-stall cycle.

## Configuration
- `HAZARD_PERF_EN`, when defined, adds three counters, each CW wide, wrapping modulo 2^CW, cleared by reset:
  - `perf_stall_cycles` increments each cycle `PC_stall`=1.
  - `perf_lu_events` increments on each H1 entry from `S_RUN`.
  - `perf_br_events` increments on each H2 entry from `S_RUN`.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

## Test plan
- `lw $8` in EXE (DMRd≠NOP, RFWr=1, rd=8) with `add` in ID (rs=8): stall=1 for 1 cycle, then `hz_state`=2 with stall=0, then 0 with stall=0.
- `lw $8` in EXE with `beq` in ID (rt=8, `use_rt`=1, branch=1): stall=1 for 2 cycles, `hz_state` sequence 0→1→2→0.
- `lw $9` in MEM with `beq` in ID (rs=9): 1 stall cycle. The same case with rd=0 or rd=31: no stall.
- `lw $8` in EXE with `sw` in ID (rt=8, rs=4): no stall, from the store exemption. The same case with rs=8: 1 stall cycle.
- H2 detected, then `freeze`=1 for 3 cycles while in `S_BR2`: outputs 0 and state stays 1 during the freeze. After release: 1 stall cycle, then `S_LU`, then `S_RUN`.
- `rstn` pulled low during `S_BR2`: outputs 0 and `hz_state`=0 immediately. With `HAZARD_PERF_EN`, the counters read 0 after reset.
